// File: rtl/memload.sv
// Byte-stream program loader: parses A5/address/length/payload/checksum frames into
// big-endian memory word writes and holds the core in reset until a 5A release byte.
module memload #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_valid,
    input  logic [7:0]        iw_byte,
    output logic              ow_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err,
    output logic [2:0]        ow_dbg_state
);

    localparam int BPW    = (DATA_W + 7) / 8;
    localparam int ABYTES = (ADDR_W + 7) / 8;
    localparam logic [7:0] ALAST = 8'(ABYTES - 1);
    localparam logic [7:0] DLAST = 8'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   word_q;
    logic [15:0]         len_q;
    logic [7:0]          csum_q;
    logic                ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                core_rst_q;
    logic                done_q;
    logic                err_q;

    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   word_d;
    logic [15:0]         len_d;
    logic                accept;

    // Handshake: a byte moves on a rising edge where iw_valid and ow_ready are both high;
    // iw_byte is ignored on every other edge.
    always_comb begin
        addr_d = ADDR_W'({addr_q, iw_byte});
        word_d = DATA_W'({word_q, iw_byte});
        len_d  = {len_q[7:0], iw_byte};
        accept = iw_valid && ready_q;
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (iw_byte == 8'hA5) begin
                            state_q    <= S_ADDR;
                            core_rst_q <= 1'b1;
                            csum_q     <= '0;
                            cnt_q      <= '0;
                            len_q      <= '0;
                        end else if (iw_byte == 8'h5A) begin
                            core_rst_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        addr_q <= addr_d;
                        csum_q <= csum_q ^ iw_byte;
                        if (cnt_q == ALAST) begin
                            cnt_q   <= '0;
                            state_q <= S_LEN;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_q  <= len_d;
                        csum_q <= csum_q ^ iw_byte;
                        if (cnt_q == 8'd1) begin
                            cnt_q   <= '0;
                            state_q <= (len_d == 16'd0) ? S_CSUM : S_DATA;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q <= word_d;
                        csum_q <= csum_q ^ iw_byte;
                        if (cnt_q == DLAST) begin
                            // Word complete: present the write and stall input for the WRITE cycle.
                            cnt_q      <= '0;
                            state_q    <= S_WRITE;
                            we_q       <= 1'b1;
                            mem_addr_q <= addr_q;
                            wdata_q    <= word_d;
                            ready_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    len_q   <= len_q - 16'd1;
                    state_q <= (len_q == 16'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (accept) begin
                        if (iw_byte == csum_q) done_q <= 1'b1;
                        else                   err_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ow_ready     = ready_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = mem_addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_core_rst  = core_rst_q;
    assign ow_busy      = (state_q != S_IDLE);
    assign ow_done      = done_q;
    assign ow_err       = err_q;
    assign ow_dbg_state = state_q;

endmodule

// File: tb/tb_memload.sv
// Directed bench for memload: frames are built by a byte-level model that predicts
// every memory write and done/err pulse; a per-cycle monitor checks the DUT against it.
module tb_memload;

    logic        iw_clk = 1'b0;
    logic        iw_rst = 1'b0;
    logic        iw_valid = 1'b0;
    logic [7:0]  iw_byte = 8'h00;
    logic        ow_ready, ow_mem_we, ow_core_rst, ow_busy, ow_done, ow_err;
    logic [23:0] ow_mem_addr, ow_mem_wdata;
    logic [2:0]  ow_dbg_state;

    memload #(.DATA_W(24), .ADDR_W(24)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_valid(iw_valid), .iw_byte(iw_byte),
        .ow_ready(ow_ready), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
        .ow_mem_wdata(ow_mem_wdata), .ow_core_rst(ow_core_rst), .ow_busy(ow_busy),
        .ow_done(ow_done), .ow_err(ow_err), .ow_dbg_state(ow_dbg_state)
    );

    always #5 iw_clk = ~iw_clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
    logic [47:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  model_csum;
    bit          prev_rst_low = 1'b1;
    bit          prev_we = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge iw_clk) prev_rst_low = !iw_rst;

    // Monitor: outputs are registered, so everything is sampled on the falling edge.
    always @(negedge iw_clk) begin
        logic [47:0] e;
        if (prev_rst_low) begin
            check("rst_ready", ow_ready, 0);
            check("rst_we", ow_mem_we, 0);
            check("rst_addr", ow_mem_addr, 0);
            check("rst_wdata", ow_mem_wdata, 0);
            check("rst_core_rst", ow_core_rst, 1);
            check("rst_busy", ow_busy, 0);
            check("rst_done", ow_done, 0);
            check("rst_err", ow_err, 0);
        end else begin
            check("ready_low_only_in_write", ow_ready, !ow_mem_we);
            if (ow_mem_we) begin
                check("we_single_cycle", prev_we, 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected",
                             ow_mem_addr, ow_mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_data", {ow_mem_addr, ow_mem_wdata}, e);
                end
            end
            if (ow_done || ow_err) check("done_err_exclusive", ow_done & ow_err, 0);
            if (ow_done) done_cnt++;
            if (ow_err) err_cnt++;
        end
        prev_we = ow_mem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge iw_clk);
        iw_valid = 1'b1;
        iw_byte  = b;
        while (!ow_ready && t < 50) begin
            @(negedge iw_clk);
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready %0d after 50 cycles, required 1", ow_ready);
        end
        @(posedge iw_clk);
        #1 iw_valid = 1'b0;
    endtask

    task automatic send_tx(input int gap);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (i == 0 && tx_q[0] == 8'hA5) begin
                @(negedge iw_clk);
                check("busy_after_cmd", ow_busy, 1);
                check("core_rst_after_cmd", ow_core_rst, 1);
            end
            repeat (gap) @(negedge iw_clk);
        end
    endtask

    // Model: builds the frame bytes and predicts writes and the done/err outcome.
    task automatic model_frame(input logic [23:0] base, input int n, input bit good,
                               input logic [7:0] bad);
        logic [15:0] nn;
        logic [23:0] a;
        nn = 16'(n);
        tx_q = {};
        tx_q.push_back(8'hA5);
        tx_q.push_back(base[23:16]);
        tx_q.push_back(base[15:8]);
        tx_q.push_back(base[7:0]);
        tx_q.push_back(nn[15:8]);
        tx_q.push_back(nn[7:0]);
        foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
        model_csum = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) model_csum ^= tx_q[i];
        tx_q.push_back(good ? model_csum : bad);
        for (int w = 0; w < n; w++) begin
            a = base + 24'(w);
            exp_q.push_back({a, pay_q[3*w], pay_q[3*w+1], pay_q[3*w+2]});
        end
        if (good || bad == model_csum) exp_done++;
        else exp_err++;
    endtask

    task automatic end_frame_check(input string tag);
        repeat (3) @(negedge iw_clk);
        check({tag, "_done_count"}, done_cnt, exp_done);
        check({tag, "_err_count"}, err_cnt, exp_err);
        check({tag, "_busy_idle"}, ow_busy, 0);
        check({tag, "_state_idle"}, ow_dbg_state, 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    initial begin
        iw_rst = 1'b0;
        repeat (3) @(negedge iw_clk);
        iw_rst = 1'b1;
        @(negedge iw_clk);
        check("ready_after_reset", ow_ready, 1);
        check("core_rst_after_reset", ow_core_rst, 1);
        check("busy_after_reset", ow_busy, 0);
        repeat (4) @(negedge iw_clk);

        pay_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_frame(24'h000010, 2, 1'b1, 8'h00);
        check("model_csum_A", model_csum, 8'h65);
        check("model_write0_A", exp_q[0], {24'h000010, 24'h112233});
        check("model_write1_A", exp_q[1], {24'h000011, 24'h445566});
        send_tx(0);
        end_frame_check("frameA");
        check("core_rst_held_A", ow_core_rst, 1);

        tx_q = {8'h5A};
        send_tx(0);
        repeat (2) @(negedge iw_clk);
        check("core_rst_released", ow_core_rst, 0);

        model_frame(24'h000010, 2, 1'b0, 8'h00);
        send_tx(0);
        end_frame_check("frameA_badcsum");
        check("core_rst_after_bad", ow_core_rst, 1);

        tx_q = {8'h3C};
        exp_err++;
        send_tx(0);
        end_frame_check("idle_badcmd");

        pay_q = {};
        model_frame(24'h000000, 0, 1'b1, 8'h00);
        check("model_csum_empty", model_csum, 8'h00);
        send_tx(0);
        end_frame_check("empty_frame");

        pay_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        model_frame(24'hFFFFFF, 2, 1'b1, 8'h00);
        check("model_wrap_addr", exp_q[1], {24'h000000, 24'h040506});
        send_tx(0);
        end_frame_check("wrap");

        tx_q = {8'hA5, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_tx(0);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(negedge iw_clk);
        check("abort_busy", ow_busy, 0);
        check("abort_core_rst", ow_core_rst, 1);
        iw_rst = 1'b1;
        end_frame_check("abort");

        pay_q = {8'h5A, 8'hAD, 8'hBE, 8'h12, 8'h34, 8'h56};
        model_frame(24'h000100, 2, 1'b1, 8'h00);
        send_tx(2);
        end_frame_check("gapped");
        check("core_rst_5A_is_data", ow_core_rst, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
